// File: rtl/dadda_tree_arb.sv
// Shares one 6-row partial-product reduction tree between two requesters.
// Round-robin grant into S1, tree result registered into the S2 response stage.

module dadda_csa #(
   parameter int unsigned W = 19
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   // Carry out of the top column is discarded: the tree output width already
   // covers the largest possible weighted sum, so the final value is exact.
   always_comb begin
      sum   = a ^ b ^ c;
      carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
   end

endmodule

// Row i carries weight 2^i; carry-save layers follow the Dadda heights 6-4-3-2.
module dadda_tree #(
   parameter int unsigned OP_W  = 13,
   parameter int unsigned RES_W = 19
) (
   input  logic [5:0][OP_W-1:0] ops,
   output logic [RES_W-1:0]     result
);

   logic [5:0][RES_W-1:0] row;
   logic [RES_W-1:0]      s1a, c1a, s1b, c1b;
   logic [RES_W-1:0]      s2, c2;
   logic [RES_W-1:0]      s3, c3;

   always_comb begin
      row = '0;
      for (int unsigned i = 0; i < 6; i++) begin
         row[i] = RES_W'(ops[i]) << i;
      end
   end

   dadda_csa #(.W(RES_W)) u_csa_1a (
      .a(row[0]), .b(row[1]), .c(row[2]), .sum(s1a), .carry(c1a)
   );

   dadda_csa #(.W(RES_W)) u_csa_1b (
      .a(row[3]), .b(row[4]), .c(row[5]), .sum(s1b), .carry(c1b)
   );

   dadda_csa #(.W(RES_W)) u_csa_2 (
      .a(s1a), .b(c1a), .c(s1b), .sum(s2), .carry(c2)
   );

   dadda_csa #(.W(RES_W)) u_csa_3 (
      .a(s2), .b(c2), .c(c1b), .sum(s3), .carry(c3)
   );

   always_comb begin
      result = s3 + c3;
   end

endmodule

module dadda_tree_arb #(
   parameter int unsigned N_OPS = 6,
   parameter int unsigned OP_W  = 13,
   parameter int unsigned RES_W = 19,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req0_valid,
   output logic                        req0_ready,
   input  logic [N_OPS-1:0][OP_W-1:0]  req0_ops,
   input  logic [TAG_W-1:0]            req0_tag,
   input  logic                        req1_valid,
   output logic                        req1_ready,
   input  logic [N_OPS-1:0][OP_W-1:0]  req1_ops,
   input  logic [TAG_W-1:0]            req1_tag,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic                        rsp_id,
   output logic [TAG_W-1:0]            rsp_tag,
   output logic [RES_W-1:0]            rsp_result,
   output logic [CNT_W-1:0]            done_cnt,
   output logic                        busy
);

   typedef enum logic {
      LAST_REQ0 = 1'b0,
      LAST_REQ1 = 1'b1
   } rr_t;

   rr_t                       rr_q;
   rr_t                       rr_d;
   logic                      s1_valid;
   logic [N_OPS-1:0][OP_W-1:0] s1_ops;
   logic                      s1_id;
   logic [TAG_W-1:0]          s1_tag;
   logic [RES_W-1:0]          tree_result;
   logic                      s2_adv;
   logic                      s1_adv;
   logic                      grant0;
   logic                      grant1;

   dadda_tree #(.OP_W(OP_W), .RES_W(RES_W)) u_tree (
      .ops    (s1_ops),
      .result (tree_result)
   );

   // Grants are masked during reset so no ready is seen while state is held clear.
   always_comb begin
      s2_adv = !rsp_valid || rsp_ready;
      s1_adv = !s1_valid || s2_adv;
      grant0 = !rst && s1_adv && req0_valid && (!req1_valid || rr_q == LAST_REQ1);
      grant1 = !rst && s1_adv && req1_valid && (!req0_valid || rr_q == LAST_REQ0);
      rr_d   = rr_q;
      if (grant0) begin
         rr_d = LAST_REQ0;
      end else if (grant1) begin
         rr_d = LAST_REQ1;
      end
      req0_ready = grant0;
      req1_ready = grant1;
      busy       = s1_valid | rsp_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= LAST_REQ1;
      end else begin
         rr_q <= rr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_ops   <= '0;
         s1_id    <= 1'b0;
         s1_tag   <= '0;
      end else if (s1_adv) begin
         s1_valid <= grant0 | grant1;
         if (grant1) begin
            s1_ops <= req1_ops;
            s1_id  <= 1'b1;
            s1_tag <= req1_tag;
         end else if (grant0) begin
            s1_ops <= req0_ops;
            s1_id  <= 1'b0;
            s1_tag <= req0_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_tag    <= '0;
         rsp_result <= '0;
      end else if (s2_adv) begin
         rsp_valid  <= s1_valid;
         rsp_id     <= s1_id;
         rsp_tag    <= s1_tag;
         rsp_result <= tree_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_cnt <= '0;
      end else if (rsp_valid && rsp_ready) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dadda_tree_arb.sv
// Scoreboard bench for dadda_tree_arb: directed vectors with hand-computed
// tree results; grants push expectations, a monitor pops on each response.

module tb_dadda_tree_arb;

   localparam int unsigned N_OPS = 6;
   localparam int unsigned OP_W  = 13;
   localparam int unsigned RES_W = 19;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned CNT_W = 16;

   typedef logic [N_OPS-1:0][OP_W-1:0] ops_t;
   typedef struct {
      ops_t             ops;
      logic [TAG_W-1:0] tag;
      logic [RES_W-1:0] res;
   } op_t;
   typedef struct {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [RES_W-1:0] res;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             req0_valid;
   logic             req0_ready;
   ops_t             req0_ops;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid;
   logic             req1_ready;
   ops_t             req1_ops;
   logic [TAG_W-1:0] req1_tag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [TAG_W-1:0] rsp_tag;
   logic [RES_W-1:0] rsp_result;
   logic [CNT_W-1:0] done_cnt;
   logic             busy;

   int               errors = 0;
   int               checks = 0;
   int               cyc = 0;
   exp_t             sb[$];
   op_t              q0[$];
   op_t              q1[$];
   int               grants[$];
   int               grant_cyc[$];
   logic [CNT_W-1:0] exp_done;
   ops_t             vops[8];
   logic [RES_W-1:0] vres[8];

   dadda_tree_arb #(
      .N_OPS(N_OPS), .OP_W(OP_W), .RES_W(RES_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ops(req0_ops), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ops(req1_ops), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
      .rsp_result(rsp_result), .done_cnt(done_cnt), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic op_t mk(input int v, input int tag);
      op_t o;
      o.ops = vops[v];
      o.tag = TAG_W'(tag);
      o.res = vres[v];
      return o;
   endfunction

   // One cycle: present queue heads at negedge, record grants before the edge.
   task automatic step(input logic rr);
      exp_t e;
      @(negedge clk);
      rsp_ready  = rr;
      req0_valid = (q0.size() > 0);
      req1_valid = (q1.size() > 0);
      if (q0.size() > 0) begin
         req0_ops = q0[0].ops;
         req0_tag = q0[0].tag;
      end
      if (q1.size() > 0) begin
         req1_ops = q1[0].ops;
         req1_tag = q1[0].tag;
      end
      #1;
      chk("both_ready", 32'(req0_ready & req1_ready), 0);
      chk("r0_ready_no_valid", 32'(req0_ready & ~req0_valid), 0);
      chk("r1_ready_no_valid", 32'(req1_ready & ~req1_valid), 0);
      if (req0_valid && req0_ready) begin
         e.id = 1'b0; e.tag = q0[0].tag; e.res = q0[0].res;
         sb.push_back(e);
         q0.delete(0);
         grants.push_back(0);
         grant_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
         e.id = 1'b1; e.tag = q1[0].tag; e.res = q1[0].res;
         sb.push_back(e);
         q1.delete(0);
         grants.push_back(1);
         grant_cyc.push_back(cyc);
      end
      cyc++;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < budget) begin
         step(1'b1);
         n++;
      end
      if (q0.size() > 0 || q1.size() > 0 || sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending q0=%0d q1=%0d sb=%0d", q0.size(), q1.size(), sb.size());
      end
   endtask

   // Monitor: done_cnt against the model every cycle, pop on each handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("done_cnt", 32'(done_cnt), 32'(exp_done));
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: id=%0d tag=%0h result=%0h", rsp_id, rsp_tag, rsp_result);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", 32'(rsp_id), 32'(e.id));
                  chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                  chk("rsp_result", 32'(rsp_result), 32'(e.res));
               end
               exp_done = exp_done + CNT_W'(1);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [TAG_W-1:0] f_tag;
      logic [RES_W-1:0] f_res;
      logic             f_id;

      // Hand-computed results: sum over rows of row_i * 2^i.
      for (int v = 0; v < 8; v++) vops[v] = '0;
      vres[0] = 19'h00000;
      for (int i = 0; i < 6; i++) vops[1][i] = 13'h1FFF;
      vres[1] = 19'h7DFC1;
      for (int i = 0; i < 6; i++) vops[2][i] = 13'h0001;
      vres[2] = 19'h0003F;
      vops[3][5] = 13'h1FFF;
      vres[3] = 19'h3FFE0;
      vops[4][0] = 13'h1234;
      vres[4] = 19'h01234;
      for (int i = 0; i < 6; i++) vops[5][i] = 13'(i + 1);
      vres[5] = 19'h00141;
      for (int i = 0; i < 6; i++) vops[6][i] = 13'h1000;
      vres[6] = 19'h3F000;
      vops[7][0] = 13'h1FFF;
      vops[7][1] = 13'h1FFF;
      vres[7] = 19'h05FFD;

      rst = 1'b1;
      rsp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_ops = '0; req1_ops = '0; req0_tag = '0; req1_tag = '0;
      exp_done = '0;

      // Reset state, with requests present during reset
      repeat (2) @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_tag", 32'(rsp_tag), 0);
      chk("rst_rsp_result", 32'(rsp_result), 0);
      chk("rst_done_cnt", 32'(done_cnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_req0_ready", 32'(req0_ready), 0);
      chk("rst_req1_ready", 32'(req1_ready), 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single op latency: zero ops, tag 3
      q0.push_back(mk(0, 3));
      step(1'b1);
      chk("t1_req0_ready", 32'(req0_ready), 1);
      step(1'b1);
      chk("t1_rsp_valid_early", 32'(rsp_valid), 0);
      chk("t1_busy", 32'(busy), 1);
      step(1'b1);
      chk("t1_rsp_valid", 32'(rsp_valid), 1);
      chk("t1_rsp_id", 32'(rsp_id), 0);
      chk("t1_rsp_tag", 32'(rsp_tag), 3);
      chk("t1_rsp_result", 32'(rsp_result), 0);
      step(1'b1);
      chk("t1_done_cnt", 32'(done_cnt), 1);
      chk("t1_idle", 32'(busy), 0);

      // Only req1: four back-to-back grants, tags 0..3
      grants.delete(); grant_cyc.delete();
      for (int t = 0; t < 4; t++) q1.push_back(mk(t + 1, t));
      drain(20);
      chk("t4_grant_count", 32'(grants.size()), 4);
      for (int k = 0; k < grants.size() && k < 4; k++) begin
         chk("t4_grant_id", 32'(grants[k]), 1);
         chk("t4_back_to_back", 32'(grant_cyc[k] - grant_cyc[0]), 32'(k));
      end

      // Both valid: alternate 0,1,... and one response per cycle
      grants.delete(); grant_cyc.delete();
      for (int t = 0; t < 8; t++) begin
         q0.push_back(mk(t, t));
         q1.push_back(mk(7 - t, 8 + t));
      end
      for (int k = 0; k < 16; k++) begin
         step(1'b1);
         if (k >= 2) chk("t2_stream_rsp_valid", 32'(rsp_valid), 1);
      end
      chk("t2_grant_count", 32'(grants.size()), 16);
      for (int k = 0; k < grants.size() && k < 16; k++) begin
         chk("t2_grant_order", 32'(grants[k]), 32'(k % 2));
         chk("t2_back_to_back", 32'(grant_cyc[k] - grant_cyc[0]), 32'(k));
      end
      drain(20);

      // Backpressure: fill, stall five cycles, release
      for (int t = 0; t < 4; t++) begin
         q0.push_back(mk(t + 4, t));
         q1.push_back(mk(t, 12 + t));
      end
      repeat (3) step(1'b1);
      f_id = 1'b0; f_tag = '0; f_res = '0;
      for (int s = 0; s < 5; s++) begin
         step(1'b0);
         chk("t3_busy", 32'(busy), 1);
         chk("t3_rsp_valid", 32'(rsp_valid), 1);
         if (s == 0) begin
            f_id = rsp_id; f_tag = rsp_tag; f_res = rsp_result;
         end else begin
            chk("t3_req0_ready_stall", 32'(req0_ready), 0);
            chk("t3_req1_ready_stall", 32'(req1_ready), 0);
            chk("t3_frozen_id", 32'(rsp_id), 32'(f_id));
            chk("t3_frozen_tag", 32'(rsp_tag), 32'(f_tag));
            chk("t3_frozen_result", 32'(rsp_result), 32'(f_res));
         end
      end
      drain(40);

      // Reset while S1 and S2 hold ops; last grant before reset is req0
      q0.push_back(mk(2, 5));
      step(1'b0);
      q0.push_back(mk(3, 6));
      step(1'b0);
      step(1'b0);
      chk("t5_pre_rsp_valid", 32'(rsp_valid), 1);
      chk("t5_pre_busy", 32'(busy), 1);
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_done_cnt", 32'(done_cnt), 0);
      sb.delete(); q0.delete(); q1.delete();
      exp_done = '0;
      @(negedge clk);
      rst = 1'b0;
      q0.push_back(mk(4, 10));
      q1.push_back(mk(5, 11));
      step(1'b1);
      chk("t5_first_grant_req0", 32'(req0_ready), 1);
      chk("t5_first_grant_not_req1", 32'(req1_ready), 0);
      drain(20);

      // done_cnt wrap from all-ones
      @(negedge clk);
      force dut.done_cnt = 16'hFFFF;
      exp_done = '1;
      #1;
      release dut.done_cnt;
      q0.push_back(mk(1, 9));
      repeat (4) step(1'b1);
      chk("t6_done_cnt_wrap", 32'(done_cnt), 0);
      drain(10);
      repeat (2) step(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dadda_tree_arb.md
Name: dadda_tree_arb

Overview:
- Shares one daddaTree reduction tree between two requesters (booth multiplier lanes).
- Each requester presents a full partial-product set (6 rows x 13 bits) with a valid/ready handshake.
- The block arbitrates round-robin and registers the winner into the tree.
- It registers the 19-bit tree result and returns it on a single response channel, tagged with requester id and user tag.

Parameters:
- N_OPS, 6, number of partial-product rows fed to daddaTree.
- OP_W, 13, width of each row.
- RES_W, 19, width of daddaTree result.
- TAG_W, 4, user tag width carried alongside each operation.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle (valid&&ready).
- req0_ops  in  N_OPS x OP_W (packed [5:0][12:0])  requester 0 partial products.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_ops  in  N_OPS x OP_W  requester 1 partial products.
- req1_tag  in  TAG_W  requester 1 tag.
- rsp_valid  out  1  response holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the op (0/1).
- rsp_tag  out  TAG_W  tag of that op.
- rsp_result  out  RES_W  daddaTree result for that op.
- done_cnt  out  CNT_W  count of responses consumed (rsp_valid&&rsp_ready), wraps.
- busy  out  1  stage S1 or S2 occupied.

Behaviour:
- Reset (async, rst=1): s1_valid=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, done_cnt=0, busy=0, req0_ready=0, req1_ready=0, rr pointer=1 (last grant = req1, so req0 wins first).
- Rsp_valid, rsp_id, rsp_tag, rsp_result and done_cnt are registers. req*_ready is combinational from the registered state and the valids; busy = s1_valid|rsp_valid.
- Pipeline: S1 register (ops, id, tag, valid) drives one internal daddaTree instance combinationally. S2 register = rsp_* captures the tree result.
- S2 advance: s2_adv = !rsp_valid || rsp_ready. On s2_adv, S2 loads S1 contents and tree result; rsp_valid <= s1_valid.
- S1 advance: s1_adv = !s1_valid || s2_adv. On s1_adv, S1 loads the granted request; s1_valid <= (grant0|grant1).
- Arbitration, evaluated only when s1_adv=1:
  - one valid -> grant it;
  - both valid -> grant the requester not granted last;
  - rr pointer updates only on an actual grant.
- reqN_ready = grantN; never both 1 in a cycle. When s1_adv=0 both readys are 0.
- Requesters hold valid/ops/tag stable until ready. The block does not check this.
- Latency: op accepted at edge k -> rsp_valid=1 after edge k+1 with its result. Throughput 1 op/cycle with rsp_ready held 1.
- Backpressure:
  - rsp_valid&&!rsp_ready freezes S2 (rsp_* stable).
  - S1 fills, then both readys drop.
  - No op is dropped or duplicated.
  - Ordering equals acceptance order.
- Simultaneous rsp accept and new grant in the same cycle: both occur; full pipeline keeps streaming.
- done_cnt increments on rsp_valid&&rsp_ready and wraps from 2^CNT_W-1 to 0.
- Starvation bound: a continuously valid requester is granted within 2 grant opportunities.
- Reset mid-operation clears all in-flight ops immediately. No response is issued for them. The first grant after reset goes to req0.
- The tree result is passed through unmodified (no truncation or extension; RES_W equals the daddaTree output width).

Test Plan:
- Reset, then req0 valid with ops=all zero, tag=3, rsp_ready=1:
  - req0_ready=1 at edge 1;
  - rsp_valid=1 after edge 2 with rsp_id=0, rsp_tag=3, rsp_result=19'h0;
  - done_cnt=1 after edge 3.
- Both requesters continuously valid, distinct random ops, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0. Each rsp_result equals a standalone golden daddaTree instance applied to the same ops. One response per cycle.
- Pipeline full, then rsp_ready=0 for 5 cycles -> rsp_* frozen, both readys=0 from the second stalled cycle, busy=1. Release -> the two in-flight results emerge in order, none lost.
- Only req1 valid for 4 ops with tags 0..3 -> 4 grants to req1 back-to-back, rsp_tag sequence 0,1,2,3, rsp_id=1.
- Assert rst for one cycle while S1 and S2 are occupied -> rsp_valid=0, busy=0, done_cnt=0 immediately. Next op with both valid -> req0 granted first.
- Force done_cnt to 16'hFFFF (via 65535 accepted ops or a bench force) and accept one more response -> done_cnt=16'h0000.
